// File: rtl/i2c_wb_fifo_pkg.sv
// Shared register map, CTRL/IRQ bit positions and the LEVEL saturation helper
// for the I2C Wishbone front end.
package i2c_wb_pkg;

  localparam logic [7:0] REG_CTRL      = 8'h00;
  localparam logic [7:0] REG_STATUS    = 8'h04;
  localparam logic [7:0] REG_TXDATA    = 8'h08;
  localparam logic [7:0] REG_RXDATA    = 8'h0C;
  localparam logic [7:0] REG_CLKDIV_LO = 8'h10;
  localparam logic [7:0] REG_CLKDIV_HI = 8'h14;
  localparam logic [7:0] REG_IRQ       = 8'h18;
  localparam logic [7:0] REG_LEVEL     = 8'h1C;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_START    = 1;
  localparam int CTRL_STOP     = 2;
  localparam int CTRL_TX_FLUSH = 3;
  localparam int CTRL_RX_FLUSH = 4;

  localparam int IRQ_RX_AVAIL = 0;
  localparam int IRQ_NACK     = 1;
  localparam int IRQ_DONE     = 2;

  function automatic logic [3:0] level_sat(input logic [6:0] cnt);
    if (cnt > 7'd15) begin
      return 4'hF;
    end else begin
      return cnt[3:0];
    end
  endfunction

endpackage

// File: rtl/i2c_wb_fifo_if.sv
// Wishbone slave bus bundle between the host and the I2C FIFO front end.
interface i2c_wb_fifo_if #(parameter int ADDR_W = 6);
  logic [ADDR_W-1:0] adr_i;
  logic [7:0]        dat_i;
  logic [7:0]        dat_o;
  logic              we_i;
  logic              stb_i;
  logic              cyc_i;
  logic              ack_o;

  modport slave  (input adr_i, dat_i, we_i, stb_i, cyc_i, output dat_o, ack_o);
  modport master (output adr_i, dat_i, we_i, stb_i, cyc_i, input dat_o, ack_o);
endinterface

// File: rtl/i2c_wb_fifo_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; storage is not reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign count = wr_ptr_r - rd_ptr_r;
  assign dout  = mem_r[rd_ptr_r[AW-1:0]];

  // A pop frees the head slot, so a push while full is accepted when paired with a pop.
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Pointer update; flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/i2c_wb_fifo.sv
// Wishbone register front end for an I2C engine: control/status registers,
// clock divider, TX/RX byte FIFOs and a level interrupt.
module i2c_wb_fifo
  import i2c_wb_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h50,
  parameter int         FIFO_DEPTH    = 8,
  parameter int         ADDR_W        = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  i2c_wb_fifo_if.slave         wb,
  output logic [15:0]          clk_div,
  output logic                 enable,
  output logic                 start_o,
  output logic                 stop_o,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 busy_i,
  input  logic                 nack_i,
  input  logic                 done_i,
  output logic                 irq_o,
  output logic [6:0]           slave_addr
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ack_r, start_r, stop_r, irq_o_r, rx_overflow_r;
  logic [7:0]    dat_r, ctrl_r, clkdiv_lo_r, clkdiv_hi_r, rd_data_s;
  logic [2:0]    irq_r, irq_next_s;
  logic          req_s, wr_s, rd_s;
  logic          sel_ctrl_s, sel_txdata_s, sel_rxdata_s, sel_irq_s;
  logic          tx_push_s, tx_pop_s, tx_flush_s, tx_full_s, tx_empty_s;
  logic          rx_pop_s, rx_flush_s, rx_full_s, rx_empty_s, rx_avail_evt_s;
  logic [7:0]    tx_dout_s, rx_dout_s;
  logic [CW-1:0] tx_count_s, rx_count_s;

  // An access is taken once; the ack it produces blocks a second take.
  assign req_s = wb.cyc_i & wb.stb_i & ~ack_r;
  assign wr_s  = req_s & wb.we_i;
  assign rd_s  = req_s & ~wb.we_i;

  assign sel_ctrl_s   = (wb.adr_i == ADDR_W'(REG_CTRL));
  assign sel_txdata_s = (wb.adr_i == ADDR_W'(REG_TXDATA));
  assign sel_rxdata_s = (wb.adr_i == ADDR_W'(REG_RXDATA));
  assign sel_irq_s    = (wb.adr_i == ADDR_W'(REG_IRQ));

  assign tx_push_s  = wr_s & sel_txdata_s;
  assign tx_pop_s   = ~tx_empty_s & tx_ready;
  assign tx_flush_s = wr_s & sel_ctrl_s & wb.dat_i[CTRL_TX_FLUSH];
  assign rx_pop_s   = rd_s & sel_rxdata_s;
  assign rx_flush_s = wr_s & sel_ctrl_s & wb.dat_i[CTRL_RX_FLUSH];
  assign rx_avail_evt_s = rx_valid & rx_empty_s & ~rx_flush_s;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push_s), .pop(tx_pop_s), .flush(tx_flush_s),
    .din(wb.dat_i), .dout(tx_dout_s), .full(tx_full_s), .empty(tx_empty_s), .count(tx_count_s)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_valid), .pop(rx_pop_s), .flush(rx_flush_s),
    .din(rx_data), .dout(rx_dout_s), .full(rx_full_s), .empty(rx_empty_s), .count(rx_count_s)
  );

  // Read data mux for the register map.
  always_comb begin
    rd_data_s = 8'h00;
    case (wb.adr_i)
      ADDR_W'(REG_CTRL):      rd_data_s = ctrl_r;
      ADDR_W'(REG_STATUS):    rd_data_s = {2'b00, rx_overflow_r, rx_empty_s, rx_full_s,
                                           tx_empty_s, tx_full_s, busy_i};
      ADDR_W'(REG_RXDATA):    rd_data_s = rx_empty_s ? 8'h00 : rx_dout_s;
      ADDR_W'(REG_CLKDIV_LO): rd_data_s = clkdiv_lo_r;
      ADDR_W'(REG_CLKDIV_HI): rd_data_s = clkdiv_hi_r;
      ADDR_W'(REG_IRQ):       rd_data_s = {5'b00000, irq_r};
      ADDR_W'(REG_LEVEL):     rd_data_s = {level_sat(7'(rx_count_s)), level_sat(7'(tx_count_s))};
      default:                rd_data_s = 8'h00;
    endcase
  end

  // IRQ next state: W1C first, then events so a same-cycle event survives the clear.
  always_comb begin
    if (wr_s && sel_irq_s) begin
      irq_next_s = irq_r & ~wb.dat_i[2:0];
    end else begin
      irq_next_s = irq_r;
    end
    irq_next_s[IRQ_RX_AVAIL] = irq_next_s[IRQ_RX_AVAIL] | rx_avail_evt_s;
    irq_next_s[IRQ_NACK]     = irq_next_s[IRQ_NACK] | nack_i;
    irq_next_s[IRQ_DONE]     = irq_next_s[IRQ_DONE] | done_i;
  end

  // Bus response, control registers, command pulses and interrupt state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_r         <= 1'b0;
      dat_r         <= 8'h00;
      ctrl_r        <= 8'h00;
      clkdiv_lo_r   <= 8'h00;
      clkdiv_hi_r   <= 8'h00;
      start_r       <= 1'b0;
      stop_r        <= 1'b0;
      irq_r         <= 3'b000;
      irq_o_r       <= 1'b0;
      rx_overflow_r <= 1'b0;
    end else begin
      ack_r   <= req_s;
      start_r <= wr_s & sel_ctrl_s & wb.dat_i[CTRL_START];
      stop_r  <= wr_s & sel_ctrl_s & wb.dat_i[CTRL_STOP];
      irq_r   <= irq_next_s;
      irq_o_r <= |(irq_r & ctrl_r[7:5]);
      if (req_s) dat_r <= rd_s ? rd_data_s : 8'h00;
      if (wr_s && sel_ctrl_s) ctrl_r <= {wb.dat_i[7:5], 4'b0000, wb.dat_i[CTRL_ENABLE]};
      if (wr_s && wb.adr_i == ADDR_W'(REG_CLKDIV_LO)) clkdiv_lo_r <= wb.dat_i;
      if (wr_s && wb.adr_i == ADDR_W'(REG_CLKDIV_HI)) clkdiv_hi_r <= wb.dat_i;
      if (rx_flush_s) begin
        rx_overflow_r <= 1'b0;
      end else if (rx_valid && rx_full_s && !rx_pop_s) begin
        rx_overflow_r <= 1'b1;
      end
    end
  end

  assign wb.ack_o   = ack_r;
  assign wb.dat_o   = dat_r;
  assign clk_div    = {clkdiv_hi_r, clkdiv_lo_r};
  assign enable     = ctrl_r[CTRL_ENABLE];
  assign start_o    = start_r;
  assign stop_o     = stop_r;
  assign tx_data    = tx_dout_s;
  assign tx_valid   = ~tx_empty_s;
  assign irq_o      = irq_o_r;
  assign slave_addr = SLAVE_ADDRESS;

endmodule

// File: tb/tb_i2c_wb_fifo.sv
// Scoreboard bench for i2c_wb_fifo: directed bus/engine stimulus queues expected
// read and TX bytes, a negedge monitor pops and compares them.
module tb_i2c_wb_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] clk_div;
  logic        enable, start_o, stop_o, tx_valid, irq_o;
  logic        tx_ready, rx_valid, busy_i, nack_i, done_i;
  logic [7:0]  tx_data, rx_data;
  logic [6:0]  slave_addr;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_rd[$];
  logic [7:0]  exp_tx[$];
  logic        prev_ack = 1'b0;

  i2c_wb_fifo_if #(.ADDR_W(6)) bus();

  i2c_wb_fifo #(.SLAVE_ADDRESS(7'h50), .FIFO_DEPTH(8), .ADDR_W(6)) dut (
    .clk(clk), .rst(rst), .wb(bus), .clk_div(clk_div), .enable(enable),
    .start_o(start_o), .stop_o(stop_o), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy_i(busy_i),
    .nack_i(nack_i), .done_i(done_i), .irq_o(irq_o), .slave_addr(slave_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic wb_access(input logic [7:0] a, input logic [7:0] d, input logic we);
    logic got;
    @(posedge clk); #1;
    bus.adr_i = a[5:0]; bus.dat_i = d; bus.we_i = we;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.ack_o) begin
        got = 1'b1;
        break;
      end
    end
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    chk("ack_seen", got, 1'b1);
  endtask

  task automatic wb_write(input logic [7:0] a, input logic [7:0] d);
    wb_access(a, d, 1'b1);
  endtask

  task automatic wb_read(input logic [7:0] a, input logic [7:0] e);
    exp_rd.push_back(e);
    wb_access(a, 8'h00, 1'b0);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  // Monitor: bus responses and TX handshakes against the scoreboards.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.ack_o) begin
        chk("ack_one_cycle", prev_ack, 1'b0);
        if (bus.we_i) begin
          chk("write_dat_o", bus.dat_o, 8'h00);
        end else if (exp_rd.size() == 0) begin
          chk("rd_queue_nonempty", exp_rd.size(), 1);
        end else begin
          chk("rd_data", bus.dat_o, exp_rd.pop_front());
        end
      end
      if (tx_valid && tx_ready) begin
        if (exp_tx.size() == 0) begin
          chk("tx_queue_nonempty", exp_tx.size(), 1);
        end else begin
          chk("tx_data", tx_data, exp_tx.pop_front());
        end
      end
    end
    prev_ack <= bus.ack_o;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.adr_i = '0; bus.dat_i = 8'h00; bus.we_i = 1'b0; bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    busy_i = 1'b0; nack_i = 1'b0; done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", bus.ack_o, 1'b0);
    chk("rst_dat_o", bus.dat_o, 8'h00);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_clk_div", clk_div, 16'h0000);
    chk("rst_enable", enable, 1'b0);
    chk("slave_addr", slave_addr, 7'h50);
    rst = 1'b1;

    wb_read(8'h04, 8'h14);
    wb_read(8'h1C, 8'h00);

    // Clock divider write/read.
    wb_write(8'h10, 8'h3F);
    wb_write(8'h14, 8'h01);
    wb_read(8'h10, 8'h3F);
    chk("clk_div", clk_div, 16'h013F);
    wb_read(8'h14, 8'h01);

    // Unmapped: write ignored but acked, read returns zero.
    wb_write(8'h24, 8'hFF);
    wb_read(8'h24, 8'h00);

    // Start and stop together, then self-clear.
    wb_write(8'h00, 8'h07);
    chk("start_pulse", start_o, 1'b1);
    chk("stop_pulse", stop_o, 1'b1);
    chk("enable_set", enable, 1'b1);
    @(posedge clk); #1;
    chk("start_clear", start_o, 1'b0);
    chk("stop_clear", stop_o, 1'b0);
    wb_read(8'h00, 8'h01);

    // TX fill past full, then drain.
    for (int i = 1; i <= 9; i++) wb_write(8'h08, 8'(i));
    wb_read(8'h1C, 8'h08);
    wb_read(8'h04, 8'h12);
    for (int i = 1; i <= 8; i++) exp_tx.push_back(8'(i));
    @(posedge clk); #1;
    tx_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    chk("tx_drained", tx_valid, 1'b0);

    // RX availability interrupt and W1C.
    wb_write(8'h00, 8'h21);
    rx_byte(8'hA5);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_rx_avail", irq_o, 1'b1);
    wb_read(8'h0C, 8'hA5);
    wb_write(8'h18, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_cleared", irq_o, 1'b0);
    wb_read(8'h18, 8'h00);

    // RX overflow, drain, flush.
    for (int i = 0; i < 8; i++) rx_byte(8'h10 + 8'(i));
    rx_byte(8'hEE);
    wb_read(8'h04, 8'h2C);
    wb_read(8'h1C, 8'h80);
    for (int i = 0; i < 8; i++) wb_read(8'h0C, 8'h10 + 8'(i));
    wb_read(8'h0C, 8'h00);
    wb_read(8'h04, 8'h34);
    rx_byte(8'h55);
    wb_write(8'h00, 8'h10);
    wb_read(8'h04, 8'h14);
    wb_read(8'h0C, 8'h00);

    // NACK event coinciding with its W1C.
    wb_write(8'h00, 8'h40);
    wb_write(8'h18, 8'h07);
    wb_read(8'h18, 8'h00);
    @(posedge clk); #1;
    bus.adr_i = 6'h18; bus.dat_i = 8'h02; bus.we_i = 1'b1;
    bus.cyc_i = 1'b1; bus.stb_i = 1'b1; nack_i = 1'b1;
    @(posedge clk); #1;
    nack_i = 1'b0;
    chk("nack_w1c_ack", bus.ack_o, 1'b1);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    wb_read(8'h18, 8'h02);
    chk("irq_nack", irq_o, 1'b1);
    @(posedge clk); #1;
    done_i = 1'b1;
    @(posedge clk); #1;
    done_i = 1'b0;
    wb_read(8'h18, 8'h06);

    // Asynchronous reset mid-access.
    for (int i = 0; i < 3; i++) wb_write(8'h08, 8'hB1 + 8'(i));
    wb_write(8'h00, 8'h01);
    chk("pre_rst_tx_valid", tx_valid, 1'b1);
    @(posedge clk); #1;
    bus.adr_i = 6'h04; bus.we_i = 1'b0; bus.cyc_i = 1'b1; bus.stb_i = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_ack", bus.ack_o, 1'b1);
    rst = 1'b0;
    #1;
    chk("async_ack", bus.ack_o, 1'b0);
    chk("async_tx_valid", tx_valid, 1'b0);
    chk("async_enable", enable, 1'b0);
    chk("async_clk_div", clk_div, 16'h0000);
    chk("async_dat_o", bus.dat_o, 8'h00);
    bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    wb_read(8'h04, 8'h14);
    wb_read(8'h1C, 8'h00);
    wb_read(8'h00, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    chk("rd_queue_drained", exp_rd.size(), 0);
    chk("tx_queue_drained", exp_tx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_wb_fifo.md
I2C_WB_FIFO -- requirements
Module: i2c_wb_fifo

Interface
REQ-001 SHALL have parameter SLAVE_ADDRESS, default 7'h50: 7-bit target address forwarded to the I2C engine.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: entries per TX and RX FIFO; power of two, 2..64.
REQ-003 SHALL have parameter ADDR_W, default 6: wishbone address width.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single clock.
- rst  in  1  reset; asynchronous, active-low.
- adr_i  in  ADDR_W  byte address.
- dat_i  in  8  write data.
- dat_o  out  8  read data.
- we_i  in  1  write enable.
- stb_i  in  1  strobe.
- cyc_i  in  1  cycle.
- ack_o  out  1  acknowledge.
- irq_o  out  1  level interrupt.
- clk_div  out  16  {CLKDIV_HI, CLKDIV_LO} to engine.
- enable  out  1  CTRL[0] to engine.
- start_o, stop_o  out  1  one-cycle command pulses.
- tx_data  out  8  TX FIFO head.
- tx_valid  out  1  TX FIFO not empty.
- tx_ready  in  1  engine consumes head.
- rx_data  in  8  received byte.
- rx_valid  in  1  engine delivers byte.
- busy_i  in  1  engine transfer active.
- nack_i  in  1  one-cycle NACK event.
- done_i  in  1  one-cycle STOP-completed event.
- slave_addr  out  7  SLAVE_ADDRESS.

Function
REQ-005 SHALL assert ack_o exactly one cycle after a cycle with cyc_i&stb_i&!ack_o; at most one ack per access; back-to-back accesses ack every second cycle.
REQ-006 SHALL decode the register map:
- 0x00 CTRL RW: [0] enable, [1] start (W1, self-clears), [2] stop (W1, self-clears), [3] tx_flush (W1), [4] rx_flush (W1), [7:5] irq_en {done, nack, rx_avail}.
- 0x04 STATUS RO: [0] busy_i, [1] tx_full, [2] tx_empty, [3] rx_full, [4] rx_empty, [5] rx_overflow (sticky).
- 0x08 TXDATA WO: push.
- 0x0C RXDATA RO: pop.
- 0x10 CLKDIV_LO RW.
- 0x14 CLKDIV_HI RW.
- 0x18 IRQ W1C: [0] rx_avail, [1] nack, [2] done.
- 0x1C LEVEL RO: [7:4] rx count, [3:0] tx count, saturating at 15.
Unmapped addresses: reads return 0x00, writes ignored, ack still given.
REQ-007 SHALL register dat_o alongside ack_o; unmapped reads and writes hold dat_o at 0x00.
REQ-008 SHALL push dat_i into the TX FIFO on an acked TXDATA write; a push when full SHALL be dropped and set no flag.
REQ-009 SHALL return the RX head on an acked RXDATA read and pop it; a read when empty SHALL return 0x00 and pop nothing.
REQ-010 SHALL pop TX on tx_valid&tx_ready; a simultaneous push and pop SHALL keep the count unchanged, including when full.
REQ-011 SHALL push rx_data on rx_valid; when full the byte SHALL be discarded and rx_overflow set; rx_overflow SHALL clear on an rx_flush write.
REQ-012 SHALL assert start_o/stop_o one cycle after the CTRL write, for one cycle; start and stop written together SHALL pulse both.
REQ-013 SHALL apply flush on the acked write cycle; flush SHALL override a same-cycle push or pop on that FIFO.
REQ-014 SHALL set IRQ bits on events (rx_avail when rx count goes 0->nonzero, nack_i, done_i); a same-cycle event SHALL win over W1C; irq_o = |(IRQ & irq_en), registered.
REQ-015 SHALL wrap FIFO pointers modulo FIFO_DEPTH, using an extra MSB for full/empty.

Reset
REQ-016 SHALL, on rst low, asynchronously clear:
- ack_o, dat_o, CTRL, CLKDIV, IRQ, rx_overflow;
- both FIFO pointers (tx_valid=0);
- start_o, stop_o, irq_o.
FIFO storage is not cleared. Deassertion resumes on the next clk edge; reset mid-access SHALL drop the access with no ack.

Structure
REQ-017 SHALL place register address constants, CTRL/IRQ bit indices and a level-saturation function in package i2c_wb_pkg.
REQ-018 SHALL instantiate sub-module sync_fifo (params WIDTH, DEPTH; ports push, pop, flush, full, empty, count) twice.

Verification
REQ-019 Write 0x10=0x3F, 0x14=0x01, then read 0x10 -> clk_div=16'h013F, read returns 0x3F, each ack exactly one cycle wide.
REQ-020 Push 9 bytes 0x01..0x09 to TXDATA with tx_ready=0, FIFO_DEPTH=8 -> LEVEL[3:0]=8, tx_full=1, 0x09 dropped; tx_ready=1 for 8 cycles yields 0x01..0x08.
REQ-021 Drive rx_valid with 0xA5 into an empty RX FIFO, irq_en rx_avail=1 -> irq_o=1; read 0x0C -> 0xA5; W1C 0x18=0x01 -> irq_o=0.
REQ-022 Fill RX with 8 bytes, then a 9th -> rx_overflow=1 and 9th lost; CTRL=0x10 -> rx_empty=1, rx_overflow=0.
REQ-023 W1C of nack in the same cycle as nack_i -> IRQ[1] stays 1.
REQ-024 Assert rst low mid-access with TX holding 3 bytes -> ack_o=0, tx_valid=0, CTRL=0 immediately, without waiting for a clk edge.
